// File: rtl/a0_trace_pkg.sv
// Shared constants and helpers for the a0 trace buffer.
package a0_trace_pkg;

    localparam int unsigned DROP_W = 8;
    localparam logic [DROP_W-1:0] DROP_MAX = 8'hFF;

    function automatic logic [DROP_W-1:0] drop_sat_inc(input logic [DROP_W-1:0] v);
        return (v == DROP_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with explicit occupancy count.
module sync_fifo_fwft #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage is reset so the read port is X-free while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/a0_trace_buffer.sv
// Captures each change of the CPU a0 register with a cycle timestamp and
// queues it in a FWFT FIFO for a slower valid/ready consumer.
module a0_trace_buffer #(
    parameter int unsigned D_WIDTH  = 32,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned TS_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     clr,
    input  logic [D_WIDTH-1:0]       a0,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [D_WIDTH-1:0]       out_data,
    output logic [TS_WIDTH-1:0]      out_ts,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);

    import a0_trace_pkg::*;

    localparam int unsigned ENTRY_W = D_WIDTH + TS_WIDTH;

    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic [D_WIDTH-1:0]  prev_q, prev_d;
    logic                primed_q, primed_d;
    logic                overflow_q, overflow_d;
    logic [DROP_W-1:0]   drop_q, drop_d;

    logic                cap, pop, drop, full, empty;
    logic [ENTRY_W-1:0]  head;

    assign cap       = en & (~primed_q | (a0 != prev_q));
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    assign drop      = cap & full & ~pop;

    always_comb begin
        ts_d       = ts_q + TS_WIDTH'(1);
        prev_d     = prev_q;
        primed_d   = primed_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (en) begin
            prev_d   = a0;
            primed_d = 1'b1;
        end
        if (drop) begin
            overflow_d = 1'b1;
            drop_d     = drop_sat_inc(drop_q);
        end
        if (clr) begin
            ts_d       = '0;
            primed_d   = 1'b0;
            overflow_d = 1'b0;
            drop_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_q       <= '0;
            prev_q     <= '0;
            primed_q   <= 1'b0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            ts_q       <= ts_d;
            prev_q     <= prev_d;
            primed_q   <= primed_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    sync_fifo_fwft #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .clr   (clr),
        .push  (cap),
        .pop   (pop),
        .din   ({a0, ts_q}),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign out_data = head[ENTRY_W-1:TS_WIDTH];
    assign out_ts   = head[TS_WIDTH-1:0];
    assign overflow = overflow_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_a0_trace_buffer.sv
// Scenario and randomized checks of a0_trace_buffer against a queue-based model.
module tb_a0_trace_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int TSW   = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            en = 1'b0;
    logic            clr = 1'b0;
    logic            out_ready = 1'b0;
    logic [DW-1:0]   a0 = '0;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [TSW-1:0]  out_ts;
    logic [4:0]      count;
    logic            overflow;
    logic [7:0]      drop_cnt;

    int vectors = 0;
    int miscompares = 0;

    // Model: ordered list of {data, ts} entries plus bookkeeping.
    logic [DW+TSW-1:0] m_q[$];
    logic [TSW-1:0]    m_ts;
    logic [DW-1:0]     m_prev;
    bit                m_primed;
    bit                m_ov;
    int                m_drops;

    a0_trace_buffer #(
        .D_WIDTH  (DW),
        .DEPTH    (DEPTH),
        .TS_WIDTH (TSW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clr       (clr),
        .a0        (a0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ts    (out_ts),
        .count     (count),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_q.delete();
        m_ts     = '0;
        m_prev   = '0;
        m_primed = 0;
        m_ov     = 0;
        m_drops  = 0;
    endtask

    task automatic model_step();
        bit do_pop;
        do_pop = (m_q.size() != 0) && out_ready;
        if (clr) begin
            m_q.delete();
            m_ts     = '0;
            m_primed = 0;
            m_ov     = 0;
            m_drops  = 0;
        end else begin
            if (do_pop) void'(m_q.pop_front());
            if (en && (!m_primed || a0 != m_prev)) begin
                if (m_q.size() < DEPTH) m_q.push_back({a0, m_ts});
                else begin
                    m_ov = 1;
                    if (m_drops < 255) m_drops++;
                end
            end
            if (en) begin
                m_prev   = a0;
                m_primed = 1;
            end
            m_ts = m_ts + 1'b1;
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input logic e, input logic c, input logic [DW-1:0] a, input logic r);
        en = e; clr = c; a0 = a; out_ready = r;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0; en = 1'b0; clr = 1'b0; out_ready = 1'b0; a0 = '0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if ({out_valid, count, overflow, drop_cnt} !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_status: got v=%b cnt=%0d ov=%b drop=%0d, want all 0", out_valid, count, overflow, drop_cnt);
        end
        vectors++;
        if ({out_data, out_ts} !== 48'd0) begin
            miscompares++;
            $display("FAIL reset_head: got data=%h ts=%h, want 0/0", out_data, out_ts);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_hold_zero();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, '0, 1'b0);
            vectors++;
            if (count !== 5'd1) begin
                miscompares++;
                $display("FAIL hold_count[%0d]: got %0d, want 1", i, count);
            end
        end
        vectors++;
        if (out_valid !== 1'b1 || out_data !== '0 || out_ts !== '0) begin
            miscompares++;
            $display("FAIL hold_head: got v=%b data=%h ts=%0d, want 1/0/0", out_valid, out_data, out_ts);
        end
    endtask

    task automatic test_sequence();
        logic [DW-1:0] seq [7] = '{1, 1, 2, 3, 3, 3, 3};
        int exp_d [3] = '{1, 2, 3};
        int exp_t [3] = '{0, 2, 3};
        int npop;
        npop = 0;
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            if (out_valid === 1'b1) begin
                vectors++;
                if (npop >= 3 || out_data !== DW'(exp_d[npop]) || out_ts !== TSW'(exp_t[npop])) begin
                    miscompares++;
                    $display("FAIL seq_pop[%0d]: got data=%0d ts=%0d, unexpected", npop, out_data, out_ts);
                end
                npop++;
            end
            cycle(1'b1, 1'b0, seq[i], 1'b1);
            vectors++;
            if (count > 5'd1) begin
                miscompares++;
                $display("FAIL seq_count[%0d]: got %0d, want <=1", i, count);
            end
        end
        vectors++;
        if (npop != 3) begin
            miscompares++;
            $display("FAIL seq_npop: got %0d pops, want 3", npop);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, DW'(100 + i), 1'b0);
        vectors++;
        if (count !== 5'd16 || overflow !== 1'b1 || drop_cnt !== 8'd4) begin
            miscompares++;
            $display("FAIL ovf_state: got cnt=%0d ov=%b drop=%0d, want 16/1/4", count, overflow, drop_cnt);
        end
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_data !== DW'(100 + i) || out_ts !== TSW'(i)) begin
                miscompares++;
                $display("FAIL ovf_drain[%0d]: got v=%b data=%0d ts=%0d, want 1/%0d/%0d", i, out_valid, out_data, out_ts, 100 + i, i);
            end
            cycle(1'b0, 1'b0, '0, 1'b1);
        end
        vectors++;
        if (count !== 5'd0 || out_valid !== 1'b0 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_empty: got cnt=%0d v=%b ov=%b, want 0/0/1", count, out_valid, overflow);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, DW'(i + 1), 1'b0);
        for (int i = 0; i < 12; i++) begin
            vectors++;
            if (out_data !== DW'(i + 1) || out_ts !== TSW'(i)) begin
                miscompares++;
                $display("FAIL b2b_head[%0d]: got data=%0d ts=%0d, want %0d/%0d", i, out_data, out_ts, i + 1, i);
            end
            cycle(1'b1, 1'b0, DW'(50 + i), 1'b1);
            vectors++;
            if (count !== 5'd16 || drop_cnt !== 8'd0 || overflow !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_state[%0d]: got cnt=%0d drop=%0d ov=%b, want 16/0/0", i, count, drop_cnt, overflow);
            end
        end
    endtask

    task automatic test_saturate_clr();
        apply_reset();
        for (int i = 0; i < 316; i++) cycle(1'b1, 1'b0, DW'(i + 1), 1'b0);
        vectors++;
        if (drop_cnt !== 8'd255 || overflow !== 1'b1 || count !== 5'd16) begin
            miscompares++;
            $display("FAIL sat_state: got drop=%0d ov=%b cnt=%0d, want 255/1/16", drop_cnt, overflow, count);
        end
        cycle(1'b0, 1'b1, '0, 1'b0);
        vectors++;
        if (count !== 5'd0 || overflow !== 1'b0 || drop_cnt !== 8'd0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_state: got cnt=%0d ov=%b drop=%0d v=%b, want 0/0/0/0", count, overflow, drop_cnt, out_valid);
        end
        cycle(1'b1, 1'b0, DW'(7), 1'b0);
        vectors++;
        if (count !== 5'd1 || out_data !== DW'(7) || out_ts !== '0) begin
            miscompares++;
            $display("FAIL clr_recapture: got cnt=%0d data=%0d ts=%0d, want 1/7/0", count, out_data, out_ts);
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, DW'(10 + i), 1'b0);
        vectors++;
        if (count !== 5'd7) begin
            miscompares++;
            $display("FAIL mid_fill: got cnt=%0d, want 7", count);
        end
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || count !== 5'd0) begin
            miscompares++;
            $display("FAIL mid_async: got v=%b cnt=%0d, want 0/0", out_valid, count);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        cycle(1'b1, 1'b0, DW'(16), 1'b0);
        vectors++;
        if (count !== 5'd1 || out_data !== DW'(16) || out_ts !== '0) begin
            miscompares++;
            $display("FAIL mid_recapture: got cnt=%0d data=%0d ts=%0d, want 1/16/0", count, out_data, out_ts);
        end
    endtask

    task automatic test_random();
        logic [DW+TSW-1:0] head;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 9) != 0, $urandom_range(0, 79) == 0,
                  DW'($urandom_range(0, 3)), $urandom_range(0, 2) == 0);
            vectors++;
            if (out_valid !== (m_q.size() != 0) || count !== 5'(m_q.size()) ||
                overflow !== m_ov || drop_cnt !== 8'(m_drops)) begin
                miscompares++;
                $display("FAIL rand_state[%0d]: got v=%b cnt=%0d ov=%b drop=%0d, want cnt=%0d ov=%b drop=%0d",
                         i, out_valid, count, overflow, drop_cnt, m_q.size(), m_ov, m_drops);
            end
            if (m_q.size() != 0) begin
                head = m_q[0];
                vectors++;
                if ({out_data, out_ts} !== head) begin
                    miscompares++;
                    $display("FAIL rand_head[%0d]: got data=%h ts=%h, want %h", i, out_data, out_ts, head);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        test_hold_zero();
        test_sequence();
        test_overflow();
        test_back_to_back();
        test_saturate_clr();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
